// File: rtl/sobel_pkg.sv
// sobel_pkg: shared constants, window type and small arithmetic helpers
// for the Sobel edge stage.
package sobel_pkg;

    // Window elements are luma samples of this width.
    localparam int SOBEL_PIX_W = 8;

    // BT.601-style luma weights, scaled by 256.
    localparam int LUMA_R_COEF = 77;
    localparam int LUMA_G_COEF = 150;
    localparam int LUMA_B_COEF = 29;
    localparam int LUMA_W      = 16;
    localparam int LUMA_SHIFT  = 8;

    // Sobel kernel: outer taps weigh 1, the middle tap weighs 2.
    localparam int SOBEL_SIDE_WEIGHT = 1;
    localparam int SOBEL_MID_WEIGHT  = 2;

    // Gradient (signed) and magnitude (unsigned) widths.
    localparam int GRAD_W = 11;
    localparam int MAG_W  = 12;

    // Cycles from an accepted input pixel to its edge output.
    localparam int LATENCY = 4;

    // 3x3 window, indexed [row][col]: row 0 is oldest (row-2), col 2 is newest.
    typedef logic [2:0][2:0][SOBEL_PIX_W-1:0] window_t;

    // Weighted sum of one kernel line: side + 2*mid + side.
    function automatic logic [GRAD_W-1:0] sobel_taps(
        input logic [SOBEL_PIX_W-1:0] a,
        input logic [SOBEL_PIX_W-1:0] b,
        input logic [SOBEL_PIX_W-1:0] c
    );
        return GRAD_W'(a) * GRAD_W'(SOBEL_SIDE_WEIGHT)
             + GRAD_W'(b) * GRAD_W'(SOBEL_MID_WEIGHT)
             + GRAD_W'(c) * GRAD_W'(SOBEL_SIDE_WEIGHT);
    endfunction

    // Absolute value; gradients never reach the most negative code.
    function automatic logic [GRAD_W-1:0] grad_abs(input logic signed [GRAD_W-1:0] g);
        return g[GRAD_W-1] ? GRAD_W'(-g) : GRAD_W'(g);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: two line memories (row-1 and row-2) sharing one
// column address. A write pushes the new luma into lb1 and moves the old
// lb1 entry down into lb0. Reads are combinational and return the
// contents from before the clock edge, so a read and write to the same
// column in one cycle behaves as read-before-write.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int PIX_W  = SOBEL_PIX_W,
    parameter int ADDR_W = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic [PIX_W-1:0]  rd_lb0,
    output logic [PIX_W-1:0]  rd_lb1
);

    logic [PIX_W-1:0] lb0_mem [IMG_W];
    logic [PIX_W-1:0] lb1_mem [IMG_W];

    assign rd_lb0 = lb0_mem[addr];
    assign rd_lb1 = lb1_mem[addr];

    // Shift the addressed column down by one line and store the new luma.
    // NOTE: the memories have no reset; clearing them would block RAM
    // inference, and stale contents only ever reach border outputs.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lb1_mem[addr] <= wr_data;
            lb0_mem[addr] <= lb1_mem[addr];
        end
    end

endmodule

// File: rtl/sobel_edge_stage.sv
// sobel_edge_stage: RGB -> luma -> 3x3 window -> Sobel |Gx|+|Gy| edge pixel.
// Four-stage pipeline, one output per accepted input (minus borders).
// Build macro EDGE_THRESH_EN: output 255/0 by comparing magnitude with
// thresh; when undefined the saturated magnitude is output and thresh is
// ignored.
module sobel_edge_stage
    import sobel_pkg::*;
#(
    parameter int IMG_W   = 640,
    parameter int COORD_W = 13,
    parameter int PIX_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   i_R,
    input  logic [PIX_W-1:0]   i_G,
    input  logic [PIX_W-1:0]   i_B,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  logic [PIX_W-1:0]   thresh,
    output logic               o_valid,
    output logic [PIX_W-1:0]   o_edge,
    output logic [COORD_W-1:0] o_row,
    output logic [COORD_W-1:0] o_col
);

    localparam int ADDR_W = $clog2(IMG_W);
    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    logic               accept;
    logic [LUMA_W-1:0]  luma_sum;
    logic [PIX_W-1:0]   luma;

    // stage_valid[n] marks valid data in pipeline stage n.
    logic [LATENCY-1:1] stage_valid;

    logic [PIX_W-1:0]   s1_y;
    logic [COORD_W-1:0] s1_row, s1_col;
    logic [COORD_W-1:0] s2_row, s2_col;
    logic [COORD_W-1:0] s3_row, s3_col;
    window_t            win;
    logic [PIX_W-1:0]   lb0_rd, lb1_rd;

    logic signed [GRAD_W-1:0] s3_gx, s3_gy;
    logic [MAG_W-1:0]   mag;
    logic [PIX_W-1:0]   edge_val;
    logic               out_ok;
    logic               border;

    // Columns beyond the active line are dropped entirely.
    assign accept   = pix_valid && (col < COORD_W'(IMG_W));
    assign luma_sum = LUMA_W'(i_R) * LUMA_W'(LUMA_R_COEF)
                    + LUMA_W'(i_G) * LUMA_W'(LUMA_G_COEF)
                    + LUMA_W'(i_B) * LUMA_W'(LUMA_B_COEF);
    assign luma     = luma_sum[LUMA_SHIFT +: PIX_W];

    // Valid bits advance every cycle; a dropped or idle input becomes a bubble.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
        end else begin
            stage_valid <= {stage_valid[LATENCY-2:1], accept};
        end
    end

    // Stage 1: capture luma and coordinates of each accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_y   <= '0;
            s1_row <= '0;
            s1_col <= '0;
        end else if (accept) begin
            s1_y   <= luma;
            s1_row <= row;
            s1_col <= col;
        end
    end

    sobel_line_buffer #(
        .IMG_W  (IMG_W),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (stage_valid[1]),
        .addr    (s1_col[ADDR_W-1:0]),
        .wr_data (s1_y),
        .rd_lb0  (lb0_rd),
        .rd_lb1  (lb1_rd)
    );

    // Stage 2: shift the window left and append {row-2, row-1, row} luma;
    // at the start of a line the two stale left columns are cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            win    <= '0;
            s2_row <= '0;
            s2_col <= '0;
        end else if (stage_valid[1]) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= (s1_col == '0) ? '0 : win[r][1];
                win[r][1] <= (s1_col == '0) ? '0 : win[r][2];
            end
            win[0][2] <= lb0_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= s1_y;
            s2_row    <= s1_row;
            s2_col    <= s1_col;
        end
    end

    // Stage 3: horizontal and vertical Sobel gradients of the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_gx  <= '0;
            s3_gy  <= '0;
            s3_row <= '0;
            s3_col <= '0;
        end else if (stage_valid[2]) begin
            s3_gx  <= $signed(sobel_taps(win[0][2], win[1][2], win[2][2])
                            - sobel_taps(win[0][0], win[1][0], win[2][0]));
            s3_gy  <= $signed(sobel_taps(win[2][0], win[2][1], win[2][2])
                            - sobel_taps(win[0][0], win[0][1], win[0][2]));
            s3_row <= s2_row;
            s3_col <= s2_col;
        end
    end

    // Stage 4 combinational part: magnitude and the edge value it maps to.
    always_comb begin
        // NOTE: each variable is assigned before any condition, so no latch forms.
        mag      = MAG_W'(grad_abs(s3_gx)) + MAG_W'(grad_abs(s3_gy));
        edge_val = '0;
`ifdef EDGE_THRESH_EN
        if (mag >= MAG_W'(thresh)) begin
            edge_val = PIX_MAX;
        end
`else
        edge_val = (mag > MAG_W'(PIX_MAX)) ? PIX_MAX : mag[PIX_W-1:0];
`endif
    end

`ifndef EDGE_THRESH_EN
    // thresh is part of the interface but has no function in this build.
    logic unused_thresh;
    assign unused_thresh = ^thresh;
`endif

    // Centre of the window is one row up and one column left of the source.
    assign out_ok = stage_valid[LATENCY-1] && (s3_row != '0) && (s3_col != '0);
    assign border = (s3_row == COORD_W'(1)) || (s3_col == COORD_W'(1));

    // Stage 4: registered outputs; they hold their value across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_edge  <= '0;
            o_row   <= '0;
            o_col   <= '0;
        end else begin
            o_valid <= out_ok;
            if (out_ok) begin
                o_edge <= border ? '0 : edge_val;
                o_row  <= s3_row - COORD_W'(1);
                o_col  <= s3_col - COORD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_stage.sv
// tb_sobel_edge_stage: directed self-checking bench for sobel_edge_stage.
// Frames are flat grey or a vertical black/white step at column 100; the
// expected edge map, output coordinates and output counts come from
// hand-derived rules below.
module tb_sobel_edge_stage;

    localparam int IMG_W   = 640;
    localparam int IMG_H   = 8;
    localparam int COORD_W = 13;
    localparam int PIX_W   = 8;
    localparam int STEP_C  = 100;

    logic               clk = 1'b0;
    logic               rst;
    logic               pix_valid;
    logic [PIX_W-1:0]   i_R, i_G, i_B;
    logic [COORD_W-1:0] row, col;
    logic [PIX_W-1:0]   thresh;
    logic               o_valid;
    logic [PIX_W-1:0]   o_edge;
    logic [COORD_W-1:0] o_row, o_col;

    always #5 clk = ~clk;

    sobel_edge_stage #(
        .IMG_W   (IMG_W),
        .COORD_W (COORD_W),
        .PIX_W   (PIX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .i_R       (i_R),
        .i_G       (i_G),
        .i_B       (i_B),
        .row       (row),
        .col       (col),
        .thresh    (thresh),
        .o_valid   (o_valid),
        .o_edge    (o_edge),
        .o_row     (o_row),
        .o_col     (o_col)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Wait for the falling edge, then present one input beat (R=G=B=grey).
    task automatic drive(input logic v, input int r, input int c, input logic [PIX_W-1:0] grey);
        @(negedge clk);
        pix_valid = v;
        row       = COORD_W'(r);
        col       = COORD_W'(c);
        i_R       = grey;
        i_G       = grey;
        i_B       = grey;
    endtask

    // mode 0: flat grey 128; mode 1: 0 left of STEP_C, 255 from STEP_C on.
    function automatic logic [PIX_W-1:0] frame_pix(input int mode, input int c);
        if (mode == 0) return 8'd128;
        return (c < STEP_C) ? 8'd0 : 8'd255;
    endfunction

    // Expected edge at window centre (r, c). Grey g gives luma g exactly,
    // so a step edge column sees |Gx| = 4*255 = 1020, saturated to 255.
    function automatic logic [PIX_W-1:0] exp_edge(input int mode, input int r, input int c);
        if (mode == 0) return 8'd0;
        if (r == 0 || c == 0) return 8'd0;
        if (c == STEP_C - 1 || c == STEP_C) return 8'd255;
        return 8'd0;
    endfunction

    // Frame monitor: outputs must arrive in raster order of centre
    // coordinates (rows from 0, cols 0..IMG_W-2) with the expected edge.
    logic mon_en    = 1'b0;
    int   mon_mode  = 0;
    int   mon_r     = 0;
    int   mon_c     = 0;
    int   mon_count = 0;

    always @(negedge clk) begin
        if (mon_en && o_valid) begin
            check("frame_row", 32'(o_row), 32'(mon_r));
            check("frame_col", 32'(o_col), 32'(mon_c));
            check("frame_edge", 32'(o_edge), 32'(exp_edge(mon_mode, mon_r, mon_c)));
            mon_count++;
            if (mon_c == IMG_W - 2) begin
                mon_c = 0;
                mon_r++;
            end else begin
                mon_c++;
            end
        end
    end

    // Full IMG_W x IMG_H frame; with gaps, each row stalls 7 cycles at
    // column 300 and ends with a dropped col=IMG_W pixel.
    task automatic run_frame(input int mode, input bit gaps);
        mon_mode  = mode;
        mon_r     = 0;
        mon_c     = 0;
        mon_count = 0;
        mon_en    = 1'b1;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (gaps && c == 300) begin
                    repeat (7) drive(1'b0, r, c, 8'hAA);
                end
                drive(1'b1, r, c, frame_pix(mode, c));
            end
            if (gaps) drive(1'b1, r, IMG_W, 8'hFF);
        end
        repeat (6) drive(1'b0, 0, 0, 8'h00);
        mon_en = 1'b0;
        check(gaps ? "frame_count_gaps" : "frame_count", 32'(mon_count),
              32'((IMG_H - 1) * (IMG_W - 1)));
    endtask

    initial begin
        thresh    = 8'd200;
        rst       = 1'b1;
        pix_valid = 1'b1;
        row       = COORD_W'(5);
        col       = COORD_W'(10);
        i_R       = 8'd200;
        i_G       = 8'd200;
        i_B       = 8'd200;

        // Reset held for three cycles with a valid pixel on the inputs.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_valid", 32'(o_valid), 32'd0);
            check("rst_edge", 32'(o_edge), 32'd0);
            check("rst_row", 32'(o_row), 32'd0);
            check("rst_col", 32'(o_col), 32'd0);
        end
        rst       = 1'b0;
        pix_valid = 1'b0;

        // Latency: (row 5, col 10) appears exactly four clocks later as (4, 9).
        drive(1'b1, 5, 10, 8'd200);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 0, 0, 8'd0);
            check("lat_valid", 32'(o_valid), 32'(k == 4));
        end
        check("lat_row", 32'(o_row), 32'd4);
        check("lat_col", 32'(o_col), 32'd9);

        // Bubbles: o_valid falls, coordinates hold.
        repeat (3) drive(1'b0, 0, 0, 8'd0);
        check("hold_valid", 32'(o_valid), 32'd0);
        check("hold_row", 32'(o_row), 32'd4);
        check("hold_col", 32'(o_col), 32'd9);

        // Border: (row 1, col 1) has centre (0, 0) and must give edge 0.
        drive(1'b1, 1, 1, 8'd200);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 0, 0, 8'd0);
            check("border_valid", 32'(o_valid), 32'(k == 4));
        end
        check("border_edge", 32'(o_edge), 32'd0);
        check("border_row", 32'(o_row), 32'd0);
        check("border_col", 32'(o_col), 32'd0);

        // Drop: col = IMG_W never produces an output.
        drive(1'b1, 5, IMG_W, 8'd200);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 0, 0, 8'd0);
            check("drop_valid", 32'(o_valid), 32'd0);
        end

        run_frame(0, 1'b0);
        run_frame(1, 1'b0);
        run_frame(1, 1'b1);

        // Reset in the middle of row 3 of a step frame.
        mon_mode  = 1;
        mon_r     = 0;
        mon_c     = 0;
        mon_count = 0;
        mon_en    = 1'b1;
        for (int r = 0; r <= 3; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (r < 3 || c <= 200) drive(1'b1, r, c, frame_pix(1, c));
            end
        end
        drive(1'b0, 0, 0, 8'd0);
        rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b0;
        check("rstmid_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        check("rstmid_hold_valid", 32'(o_valid), 32'd0);
        rst = 1'b0;

        // Resume at (3, 201): first output exactly four clocks later, centre (2, 200).
        drive(1'b1, 3, 201, frame_pix(1, 201));
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 3, 201 + k, frame_pix(1, 201 + k));
            check("rstmid_lat_valid", 32'(o_valid), 32'(k == 4));
        end
        check("rstmid_row", 32'(o_row), 32'd2);
        check("rstmid_col", 32'(o_col), 32'd200);
        repeat (6) drive(1'b0, 0, 0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
